// File: rtl/icache_pkg.sv
// Shared types and address-field constants for the instruction-cache refill path.
// The line layout puts word offset 0 in the most significant 32 bits.
package icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_CHECK,
    ST_REFILL,
    ST_FILL
  } state_e;

  localparam int TAG_MSB = 31;
  localparam int TAG_LSB = 7;
  localparam int IDX_MSB = 6;
  localparam int IDX_LSB = 4;
  localparam int OFF_MSB = 3;
  localparam int OFF_LSB = 2;
  localparam int LINE_W  = 128;
  localparam int WORD_W  = 32;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        off);
    logic [WORD_W-1:0] w;
    case (off)
      2'd0:    w = line[127:96];
      2'd1:    w = line[95:64];
      2'd2:    w = line[63:32];
      default: w = line[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/icache_line_assembler.sv
// Beat counter plus line buffer: collects one 32-bit word per accepted beat
// into its slot of a 128-bit line (beat 0 lands in the top word).
module icache_line_assembler
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              beat_en,
  input  logic [WORD_W-1:0] wdata,
  output logic [1:0]        beat,
  output logic              last,
  output logic [LINE_W-1:0] line
);

  logic [1:0]        beat_q, beat_d;
  logic [LINE_W-1:0] line_q, line_d;

  always_comb begin
    beat_d = beat_q;
    line_d = line_q;
    if (clr) begin
      beat_d = 2'd0;
    end else if (beat_en) begin
      for (int w = 0; w < LINE_WORDS; w++) begin
        if (beat_q == w[1:0]) line_d[LINE_W-1-WORD_W*w -: WORD_W] = wdata;
      end
      beat_d = beat_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= 2'd0;
      line_q <= '0;
    end else begin
      beat_q <= beat_d;
      line_q <= line_d;
    end
  end

  assign beat = beat_q;
  assign last = (beat_q == 2'(LINE_WORDS - 1));
  assign line = line_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Fetch sequencer for the 8-line direct-mapped icache: lookup, refill on miss,
// replay the lookup after the fill, and keep saturating hit/miss statistics.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_req,
  input  logic [31:0]               cpu_addr,
  output logic                      cpu_stall,
  output logic                      cpu_valid,
  output logic [31:0]               cpu_instr,
  output logic [31:0]               lk_addr,
  input  logic                      lk_hit,
  input  logic [31:0]               lk_instr,
  output logic                      fill_we,
  output logic [IDX_MSB-IDX_LSB:0]  fill_index,
  output logic [TAG_MSB-TAG_LSB:0]  fill_tag,
  output logic [LINE_W-1:0]         fill_line,
  output logic                      mem_req,
  output logic [31:0]               mem_addr,
  input  logic [31:0]               mem_rdata,
  input  logic                      mem_ack,
  output logic [CNT_W-1:0]          hit_cnt,
  output logic [CNT_W-1:0]          miss_cnt,
  output logic                      refill_err
);

  state_e            state_q, state_d;
  logic [31:0]       req_addr_q, req_addr_d;
  logic              replay_q, replay_d;
  logic              cpu_valid_q, cpu_valid_d;
  logic [31:0]       cpu_instr_q, cpu_instr_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic              refill_err_q, refill_err_d;

  logic              asm_clr, asm_en, asm_last;
  logic [1:0]        asm_beat;
  logic [LINE_W-1:0] asm_line;

  assign asm_clr = (state_q == ST_CHECK) && !lk_hit && !replay_q;
  assign asm_en  = (state_q == ST_REFILL) && mem_ack;

  icache_line_assembler #(.LINE_WORDS(LINE_WORDS)) u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (asm_clr),
    .beat_en (asm_en),
    .wdata   (mem_rdata),
    .beat    (asm_beat),
    .last    (asm_last),
    .line    (asm_line)
  );

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    replay_d     = replay_q;
    cpu_valid_d  = 1'b0;
    cpu_instr_d  = cpu_instr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    refill_err_d = refill_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          req_addr_d = cpu_addr;
          replay_d   = 1'b0;
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: state_d = ST_CHECK;
      ST_CHECK: begin
        if (lk_hit) begin
          cpu_valid_d = 1'b1;
          cpu_instr_d = lk_instr;
          state_d     = ST_IDLE;
          if (!replay_q && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end else if (!replay_q) begin
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          state_d = ST_REFILL;
        end else begin
          // Replay still missed: hand back the word we just fetched, never loop.
          refill_err_d = 1'b1;
          cpu_valid_d  = 1'b1;
          cpu_instr_d  = line_word(asm_line, req_addr_q[OFF_MSB:OFF_LSB]);
          state_d      = ST_IDLE;
        end
      end
      ST_REFILL: begin
        if (mem_ack && asm_last) state_d = ST_FILL;
      end
      ST_FILL: begin
        replay_d = 1'b1;
        state_d  = ST_LOOKUP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_addr_q   <= '0;
      replay_q     <= 1'b0;
      cpu_valid_q  <= 1'b0;
      cpu_instr_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      refill_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      replay_q     <= replay_d;
      cpu_valid_q  <= cpu_valid_d;
      cpu_instr_q  <= cpu_instr_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      refill_err_q <= refill_err_d;
    end
  end

  assign cpu_stall  = (state_q != ST_IDLE);
  assign cpu_valid  = cpu_valid_q;
  assign cpu_instr  = cpu_instr_q;
  assign lk_addr    = req_addr_q;
  assign fill_we    = (state_q == ST_FILL);
  assign fill_index = req_addr_q[IDX_MSB:IDX_LSB];
  assign fill_tag   = req_addr_q[TAG_MSB:TAG_LSB];
  assign fill_line  = asm_line;
  assign mem_req    = (state_q == ST_REFILL);
  assign mem_addr   = {req_addr_q[TAG_MSB:OFF_MSB+1], asm_beat, 2'b00};
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;
  assign refill_err = refill_err_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl: a tag/data array and a wait-state
// memory are modelled here, and each fetch is scored against expected results.
module tb_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_req, mem_ack;
  logic [31:0]  cpu_addr, mem_rdata;
  logic         lk_hit;
  logic [31:0]  lk_instr;

  logic         cpu_stall, cpu_valid, fill_we, mem_req, refill_err;
  logic [31:0]  cpu_instr, lk_addr, mem_addr;
  logic [2:0]   fill_index;
  logic [24:0]  fill_tag;
  logic [127:0] fill_line;
  logic [15:0]  hit_cnt, miss_cnt;

  logic         s_stall, s_valid, s_fill_we, s_mem_req, s_err;
  logic [31:0]  s_instr, s_lk_addr, s_mem_addr;
  logic [2:0]   s_fill_index;
  logic [24:0]  s_fill_tag;
  logic [127:0] s_fill_line;
  logic [2:0]   s_hit_cnt, s_miss_cnt;

  always #5 clk = ~clk;

  icache_refill_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_stall(cpu_stall), .cpu_valid(cpu_valid), .cpu_instr(cpu_instr),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_instr(lk_instr),
    .fill_we(fill_we), .fill_index(fill_index), .fill_tag(fill_tag), .fill_line(fill_line),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .refill_err(refill_err)
  );

  // Narrow-counter copy sharing the same stimulus, so saturation is reached quickly.
  icache_refill_ctrl #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_stall(s_stall), .cpu_valid(s_valid), .cpu_instr(s_instr),
    .lk_addr(s_lk_addr), .lk_hit(lk_hit), .lk_instr(lk_instr),
    .fill_we(s_fill_we), .fill_index(s_fill_index), .fill_tag(s_fill_tag), .fill_line(s_fill_line),
    .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt), .refill_err(s_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [127:0] exp_line(input logic [31:0] a);
    return {memfn({a[31:4], 4'h0}), memfn({a[31:4], 4'h4}),
            memfn({a[31:4], 4'h8}), memfn({a[31:4], 4'hC})};
  endfunction

  // Physical cache array (written by the DUT's fills) and the bench's expected view.
  bit          arr_v[8];
  logic [24:0] arr_tag[8];
  logic [31:0] arr_dat[8][4];
  bit          mdl_v[8];
  logic [24:0] mdl_tag[8];
  logic [31:0] mdl_dat[8][4];
  int          mdl_hits, mdl_misses;
  bit          mdl_err;

  assign lk_hit   = arr_v[lk_addr[6:4]] && (arr_tag[lk_addr[6:4]] == lk_addr[31:7]);
  assign lk_instr = arr_dat[lk_addr[6:4]][lk_addr[3:2]];

  logic [31:0] exp_base = '0;
  int          mem_wait = 0;
  int          acks = 0;
  int          fills = 0;
  int          wcnt = 0;
  bit          saw_mreq = 1'b0;
  bit          drop_fill = 1'b0;

  // Memory: mem_wait idle cycles then one ack per beat; stray acks when not requested.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end else if (mem_req) begin
        saw_mreq = 1'b1;
        chk("mem_addr", mem_addr, {exp_base[31:4], acks[1:0], 2'b00});
        if (wcnt >= mem_wait) begin
          mem_ack = 1'b1;
          mem_rdata = memfn(mem_addr);
          acks++;
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
        wcnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && fill_we) begin
        fills++;
        chk("fill_index", fill_index, exp_base[6:4]);
        chk("fill_tag", fill_tag, exp_base[31:7]);
        chk("fill_line", fill_line, exp_line(exp_base));
        if (!drop_fill) begin
          arr_v[fill_index] = 1'b1;
          arr_tag[fill_index] = fill_tag;
          for (int w = 0; w < 4; w++) arr_dat[fill_index][w] = fill_line[127-32*w -: 32];
        end
      end
    end
  end

  task automatic check_counters();
    chk("hit_cnt", hit_cnt, (mdl_hits > 65535) ? 65535 : mdl_hits);
    chk("miss_cnt", miss_cnt, (mdl_misses > 65535) ? 65535 : mdl_misses);
    chk("hit_sat", s_hit_cnt, (mdl_hits > 7) ? 7 : mdl_hits);
    chk("miss_sat", s_miss_cnt, (mdl_misses > 7) ? 7 : mdl_misses);
    chk("refill_err", refill_err, mdl_err);
  endtask

  task automatic run_txn(input logic [31:0] addr, input int wait_c, input bit drop);
    logic [2:0]  idx;
    logic [1:0]  off;
    logic [31:0] exp_instr;
    bit          exp_hit, got;
    int          lat, n;
    idx = addr[6:4];
    off = addr[3:2];
    exp_hit = mdl_v[idx] && (mdl_tag[idx] == addr[31:7]);
    if (exp_hit) begin
      exp_instr = mdl_dat[idx][off];
      lat = 3;
      mdl_hits++;
    end else begin
      exp_instr = memfn({addr[31:4], off, 2'b00});
      lat = 6 + 4 * (wait_c + 1);
      mdl_misses++;
      if (drop) mdl_err = 1'b1;
      else begin
        mdl_v[idx] = 1'b1;
        mdl_tag[idx] = addr[31:7];
        for (int w = 0; w < 4; w++) mdl_dat[idx][w] = memfn({addr[31:4], w[1:0], 2'b00});
      end
    end
    @(negedge clk);
    exp_base = addr; mem_wait = wait_c; drop_fill = drop;
    acks = 0; fills = 0; saw_mreq = 1'b0;
    cpu_addr = addr;
    cpu_req = 1'b1;
    @(posedge clk);
    n = 0;
    got = 1'b0;
    while (n < 300 && !got) begin
      @(negedge clk);
      n++;
      if (cpu_valid) begin
        got = 1'b1;
        cpu_req = 1'b0;
      end else begin
        chk("stall", cpu_stall, 1'b1);
        chk("lk_addr", lk_addr, addr);
        cpu_req = $urandom_range(0, 1);
        cpu_addr = $urandom;
      end
    end
    chk("valid_seen", got, 1'b1);
    chk("latency", n, lat);
    chk("instr", cpu_instr, exp_instr);
    chk("stall_idle", cpu_stall, 1'b0);
    chk("acks", acks, exp_hit ? 0 : 4);
    chk("fills", fills, exp_hit ? 0 : 1);
    chk("mreq_seen", saw_mreq, !exp_hit);
    check_counters();
    @(negedge clk);
    chk("valid_pulse", cpu_valid, 1'b0);
    chk("lk_hold", lk_addr, addr);
  endtask

  initial begin
    int n;
    cpu_req = 1'b0;
    cpu_addr = '0;
    for (int i = 0; i < 8; i++) begin
      arr_v[i] = 1'b0; arr_tag[i] = '0; mdl_v[i] = 1'b0; mdl_tag[i] = '0;
      for (int w = 0; w < 4; w++) begin arr_dat[i][w] = '0; mdl_dat[i][w] = '0; end
    end
    mdl_hits = 0; mdl_misses = 0; mdl_err = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_valid", cpu_valid, 1'b0);
    chk("rst_instr", cpu_instr, 32'h0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_fill_we", fill_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_fill_line", fill_line, 128'h0);
    check_counters();
    rst_n = 1'b1;

    run_txn(32'h0000_0040, 0, 1'b0);
    arr_dat[4][2] = 32'hDEAD_BEEF;
    mdl_dat[4][2] = 32'hDEAD_BEEF;
    run_txn(32'h0000_0048, 0, 1'b0);
    run_txn(32'h0000_0100, 3, 1'b0);
    run_txn(32'h0000_0088, 0, 1'b1);
    drop_fill = 1'b0;

    // Reset after the third beat's ack: partial line must be discarded.
    @(negedge clk);
    exp_base = 32'h0000_01C0; mem_wait = $urandom_range(0, 2);
    acks = 0; fills = 0;
    cpu_addr = 32'h0000_01C0;
    cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    n = 0;
    while (acks < 3 && n < 200) begin @(posedge clk); n++; end
    chk("rst_wait", acks, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_req", mem_req, 1'b0);
    chk("mid_rst_stall", cpu_stall, 1'b0);
    chk("mid_rst_fill_we", fill_we, 1'b0);
    chk("mid_rst_lk_addr", lk_addr, 32'h0);
    mdl_hits = 0; mdl_misses = 0; mdl_err = 1'b0;
    check_counters();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_fills", fills, 0);

    run_txn(32'h0000_01C0, 0, 1'b0);
    for (int i = 0; i < 10; i++) run_txn(32'h0000_01C4 | (i & 32'hC), $urandom_range(0, 3), 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 3), 7'h0} | ($urandom & 32'h7F);
      if ($urandom_range(0, 9) == 0) a[31:28] = 4'hF;
      run_txn(a, $urandom_range(0, 2), ($urandom_range(0, 9) == 0));
    end
    drop_fill = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Sequencer for the 8-line direct-mapped instruction cache (128-bit lines, 4×32-bit words, tag = addr[31:7], index = addr[6:4], word offset = addr[3:2]).
- Accepts CPU fetch requests and issues a lookup to the cache array.
- On a miss, fetches the line from memory as four 32-bit beats over a req/ack handshake, assembles it, and writes it into the array with an explicit write strobe.
- Replays the lookup after the fill, then returns the instruction; also keeps hit/miss statistics.

Parameters:
- CNT_W, 16, width of the saturating hit and miss counters.
- LINE_WORDS, 4, words per line; fixed at 4, and the beat counter is 2 bits.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  reset.
- cpu_req  in  1  fetch request; sampled only in IDLE.
- cpu_addr  in  32  fetch byte address; bits [1:0] ignored.
- cpu_stall  out  1  high whenever state ≠ IDLE.
- cpu_valid  out  1  one-cycle pulse; cpu_instr is valid in that cycle.
- cpu_instr  out  32  returned instruction.
- lk_addr  out  32  lookup address to the cache array; equals the latched req_addr.
- lk_hit  in  1  cache hit, valid one cycle after lookup issue.
- lk_instr  in  32  cache word, valid with lk_hit.
- fill_we  out  1  one-cycle line write strobe.
- fill_index  out  3  req_addr[6:4].
- fill_tag  out  25  req_addr[31:7].
- fill_line  out  128  assembled line; word offset 0 in [127:96], offset 3 in [31:0].
- mem_req  out  1  memory read request.
- mem_addr  out  32  {req_addr[31:4], beat[1:0], 2'b00}.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  beat-complete strobe.
- hit_cnt  out  CNT_W  saturating count of first-lookup hits.
- miss_cnt  out  CNT_W  saturating count of first-lookup misses.
- refill_err  out  1  sticky flag: a replay lookup missed.

Behaviour:
- Reset is asynchronous and active-low on rst_n. Every register clears immediately on assertion:
  - state = IDLE, beat = 0, line buffer = 0, req_addr = 0, replay flag = 0.
  - cpu_valid = 0, cpu_instr = 0, fill_we = 0, mem_req = 0, counters = 0, refill_err = 0.
  - Reset mid-refill discards the partial line; no fill_we is issued.
- States: IDLE, LOOKUP, CHECK, REFILL, FILL.
- IDLE: cpu_stall = 0. If cpu_req = 1, latch cpu_addr into req_addr, clear the replay flag, go to LOOKUP.
- LOOKUP: lk_addr is stable for one cycle; the cache array samples it at the closing edge. Go to CHECK.
- CHECK:
  - lk_hit = 1: register cpu_instr = lk_instr and pulse cpu_valid in the next cycle (registered outputs). Go to IDLE. If the replay flag is 0, increment hit_cnt.
  - lk_hit = 0 with replay flag 0: increment miss_cnt, set beat = 0, go to REFILL.
  - lk_hit = 0 with replay flag 1: set refill_err. Deliver the buffered word line_buf[req_addr[3:2]] with a cpu_valid pulse, go to IDLE. No further refill.
- REFILL:
  - mem_req = 1; mem_addr is held constant until mem_ack.
  - On mem_ack, store mem_rdata into buffer word [beat] and increment beat.
  - If the acked beat is 3: drop mem_req in the next cycle and go to FILL.
  - Otherwise mem_req stays high with the next mem_addr. Back-to-back acks give one beat per cycle.
  - mem_ack outside REFILL is ignored.
- FILL: fill_we = 1 for exactly one cycle with fill_index, fill_tag and fill_line. Set the replay flag, go to LOOKUP.
- Latency, with request accepted at edge 0:
  - Hit: cpu_valid high in cycle 3.
  - Miss with zero-wait memory (ack in the same cycle as req): REFILL occupies cycles 3..6, FILL is cycle 7, LOOKUP cycle 8, CHECK cycle 9, cpu_valid in cycle 10.
- cpu_req while cpu_stall = 1 is ignored; the CPU holds the request.
- Counters saturate at all-ones and do not wrap.
- refill_err clears only on reset.

Decomposition:
- Shared package icache_pkg holds:
  - The state enum.
  - Constants TAG_MSB = 31, TAG_LSB = 7, IDX_MSB = 6, IDX_LSB = 4, OFF_MSB = 3, OFF_LSB = 2, LINE_W = 128.
- One natural sub-module, icache_line_assembler: the beat counter plus the 128-bit buffer with the word-order mapping. It is also reusable for a future data cache.
- Counters stay inline.

Test Plan:
- Reset then cpu_req with addr 0x0000_0040, lk_hit = 0 → miss_cnt = 1.
  - mem_addr sequence 0x40, 0x44, 0x48, 0x4C.
  - fill_index = 4, fill_tag = 0; fill_line = {w0, w1, w2, w3} with w0 in [127:96].
  - Replay lk_hit = 1 → cpu_valid with word 0.
- Hit at 0x0000_0048 (lk_hit = 1, lk_instr = 0xDEADBEEF) → cpu_valid in cycle 3, cpu_instr = 0xDEADBEEF, hit_cnt + 1, mem_req never asserted.
- Memory with 3 wait cycles per beat → mem_addr held across waits, exactly 4 acks consumed, one fill_we pulse, cpu_stall high throughout.
- Replay lookup forced to miss with addr 0x0000_0088 → refill_err = 1, cpu_instr = buffered word 2, no second REFILL.
- rst_n asserted low after beat 2's ack:
  - Immediately: mem_req = 0, state = IDLE, no fill_we.
  - After rst_n release, a new miss at the same address refills from beat 0.
- Force hit_cnt to 0xFFFF, then another hit → hit_cnt stays 0xFFFF.
- cpu_req pulses during a refill → ignored; no latch change and no extra cpu_valid.
